// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter: state encoding,
// requester count and the rotating-priority pick function.
package rr_arbiter4_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // First set request bit found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter4_dec.sv
// 2-to-4 decoder with enable; drives the one-hot grant vector from the grant index.
module rr_arbiter4_dec (
    input  logic [1:0] w,
    input  logic       en,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0000;
        if (en) begin
            y = 4'b0001 << w;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// 4-requester round-robin arbiter with bounded hold. Every ownership change passes
// through one IDLE cycle, and a contended owner is preempted after MAX_HOLD cycles.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic [1:0] grant_id,
    output logic       preempt
);

    arb_state_e       state, state_n;
    logic [1:0]       ptr, ptr_n;
    logic [1:0]       id_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic             preempt_n;
    logic             others_waiting;
    logic             at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ptr      <= 2'b00;
            grant_id <= 2'b00;
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            grant_id <= id_n;
            hold_cnt <= hold_n;
            preempt  <= preempt_n;
        end
    end

    assign others_waiting = |(req & ~(4'b0001 << grant_id));
    assign at_limit       = (hold_cnt == CNT_W'(MAX_HOLD - 1));

    // Release takes precedence over timeout, so preempt only fires while the owner still requests.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        id_n      = grant_id;
        hold_n    = hold_cnt;
        preempt_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_n = ST_GRANT;
                    id_n    = rr_pick(req, ptr);
                    hold_n  = '0;
                end
            end
            ST_GRANT: begin
                if (!req[grant_id]) begin
                    state_n = ST_IDLE;
                    ptr_n   = grant_id + 2'd1;
                end else if (at_limit && others_waiting) begin
                    state_n   = ST_IDLE;
                    ptr_n     = grant_id + 2'd1;
                    preempt_n = 1'b1;
                end else if (at_limit) begin
                    hold_n = '0;
                end else begin
                    hold_n = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign grant_valid = (state == ST_GRANT);

    rr_arbiter4_dec u_dec (
        .w  (grant_id),
        .en (grant_valid),
        .y  (grant)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed vector table, hand-written timeout and
// uncontended sequences, then randomized requests against a behavioural model.
module tb_rr_arbiter4;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       preempt;

    int tests = 0;
    int fails = 0;

    // Behavioural model: owner (-1 when nobody holds), cycles held, next priority slot.
    int m_owner = -1;
    int m_last  = 0;
    int m_prio  = 0;
    int m_held  = 0;
    int m_pre   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] g;
        logic       v;
        logic [1:0] id;
        logic       p;
    } vec_t;

    vec_t vecs[26];

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .preempt     (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] r, input logic rs);
        m_pre = 0;
        if (rs) begin
            m_owner = -1;
            m_last  = 0;
            m_prio  = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            if (r != 4'b0000) begin
                for (int k = 3; k >= 0; k--) begin
                    if (r[(m_prio + k) % 4]) m_owner = (m_prio + k) % 4;
                end
                m_last = m_owner;
                m_held = 1;
            end
        end else if (!r[m_owner]) begin
            m_prio  = (m_owner + 1) % 4;
            m_owner = -1;
        end else if (m_held == MAX_HOLD) begin
            if ((r & ~(4'b0001 << m_owner)) != 4'b0000) begin
                m_pre   = 1;
                m_prio  = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                m_held = 1;
            end
        end else begin
            m_held++;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [3:0] exp_g;
        exp_g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check({tag, " grant"}, grant, exp_g);
        check({tag, " grant_valid"}, {3'b000, grant_valid}, {3'b000, m_owner >= 0});
        check({tag, " grant_id"}, {2'b00, grant_id}, 4'(m_last));
        check({tag, " preempt"}, {3'b000, preempt}, 4'(m_pre));
        check({tag, " onehot0"}, {3'b000, $onehot0(grant)}, 4'b0001);
        check({tag, " valid_consistent"}, {3'b000, grant != 4'b0000}, {3'b000, grant_valid});
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic rs, input string tag);
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        checkOutput(tag);
    endtask

    task automatic expectGrant(input string tag, input logic [3:0] g, input logic p);
        check({tag, " grant_const"}, grant, g);
        check({tag, " preempt_const"}, {3'b000, preempt}, {3'b000, p});
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;

        // Reset, single requester, fairness rotation and mid-grant reset.
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[4]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[6]  = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[7]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[8]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[9]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[10] = '{1'b0, 4'b1110, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[11] = '{1'b0, 4'b1111, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[12] = '{1'b0, 4'b1111, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[13] = '{1'b0, 4'b1101, 4'b0000, 1'b0, 2'd1, 1'b0};
        vecs[14] = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[15] = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0};
        vecs[16] = '{1'b0, 4'b1011, 4'b0000, 1'b0, 2'd2, 1'b0};
        vecs[17] = '{1'b0, 4'b1111, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[18] = '{1'b0, 4'b1111, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[19] = '{1'b0, 4'b0111, 4'b0000, 1'b0, 2'd3, 1'b0};
        vecs[20] = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[21] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[22] = '{1'b0, 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0};
        vecs[23] = '{1'b1, 4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[24] = '{1'b0, 4'b1001, 4'b0001, 1'b1, 2'd0, 1'b0};
        vecs[25] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};

        for (int i = 0; i < 26; i++) begin
            applyStimulus(vecs[i].req, vecs[i].rst, $sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl_grant", i), grant, vecs[i].g);
            check($sformatf("vec%0d tbl_valid", i), {3'b000, grant_valid}, {3'b000, vecs[i].v});
            check($sformatf("vec%0d tbl_id", i), {2'b00, grant_id}, {2'b00, vecs[i].id});
            check($sformatf("vec%0d tbl_preempt", i), {3'b000, preempt}, {3'b000, vecs[i].p});
        end

        // Contended timeout: requester 0 then requester 1, each for MAX_HOLD cycles.
        applyStimulus(4'b0011, 1'b1, "to_rst");
        for (int i = 0; i < MAX_HOLD; i++) begin
            applyStimulus(4'b0011, 1'b0, $sformatf("to_own0_%0d", i));
            expectGrant($sformatf("to_own0_%0d", i), 4'b0001, 1'b0);
        end
        applyStimulus(4'b0011, 1'b0, "to_gap0");
        expectGrant("to_gap0", 4'b0000, 1'b1);
        for (int i = 0; i < MAX_HOLD; i++) begin
            applyStimulus(4'b0011, 1'b0, $sformatf("to_own1_%0d", i));
            expectGrant($sformatf("to_own1_%0d", i), 4'b0010, 1'b0);
        end
        applyStimulus(4'b0011, 1'b0, "to_gap1");
        expectGrant("to_gap1", 4'b0000, 1'b1);

        // Owner drops its request exactly on the timeout cycle: plain release, no preempt.
        applyStimulus(4'b0011, 1'b1, "sim_rst");
        for (int i = 0; i < MAX_HOLD; i++) begin
            applyStimulus(4'b0011, 1'b0, $sformatf("sim_own0_%0d", i));
        end
        applyStimulus(4'b0010, 1'b0, "sim_release");
        expectGrant("sim_release", 4'b0000, 1'b0);
        applyStimulus(4'b0010, 1'b0, "sim_next");
        expectGrant("sim_next", 4'b0010, 1'b0);

        // Uncontended owner keeps the grant past MAX_HOLD.
        applyStimulus(4'b0100, 1'b1, "unc_rst");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b0100, 1'b0, $sformatf("unc_%0d", i));
            expectGrant($sformatf("unc_%0d", i), 4'b0100, 1'b0);
        end

        // Randomized traffic; owners usually keep requesting so timeouts occur.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r;
            logic       rs;
            r  = 4'($urandom_range(0, 15));
            if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
            rs = ($urandom_range(0, 63) == 0);
            applyStimulus(r, rs, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
